// File: rtl/nrzi_dec.sv
// NRZI line decoder with SYNC detection, payload delivery and packet-length guard.
// Define NRZI_DEC_UNSTUFF_EN to enable bit unstuffing and stuffing-violation detection.
module nrzi_dec #(
   parameter logic [6:0] MAX_BITS = 7'd92
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bstr_in,
   input  logic       bstr_in_valid,
   input  logic       eop_in,
   output logic       bstr_out,
   output logic       bstr_out_valid,
   output logic       pkt_start,
   output logic       pkt_end,
   output logic       stuff_err,
   output logic [6:0] bit_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   logic [1:0] state_reg, state_next;
   logic       prev_line_reg, prev_line_next;
   logic [2:0] zero_cnt_reg, zero_cnt_next;
   logic [6:0] bit_cnt_reg, bit_cnt_next;
   logic       bstr_out_reg, bstr_out_next;
   logic       bstr_out_valid_reg, bstr_out_valid_next;
   logic       pkt_start_reg, pkt_start_next;
   logic       pkt_end_reg, pkt_end_next;
   logic       stuff_err_reg, stuff_err_next;
`ifdef NRZI_DEC_UNSTUFF_EN
   logic [2:0] ones_cnt_reg, ones_cnt_next;
`endif

   logic dec_bit;
   logic deliver;

   // No line transition decodes as 1, a transition as 0.
   assign dec_bit = ~(bstr_in ^ prev_line_reg);

   always_comb begin
      state_next          = state_reg;
      zero_cnt_next       = zero_cnt_reg;
      bit_cnt_next        = bit_cnt_reg;
      bstr_out_next       = 1'b0;
      bstr_out_valid_next = 1'b0;
      pkt_start_next      = 1'b0;
      pkt_end_next        = 1'b0;
      stuff_err_next      = 1'b0;
      deliver             = 1'b0;
`ifdef NRZI_DEC_UNSTUFF_EN
      ones_cnt_next       = ones_cnt_reg;
`endif

      if (eop_in)
         prev_line_next = 1'b1;
      else if (bstr_in_valid)
         prev_line_next = bstr_in;
      else
         prev_line_next = prev_line_reg;

      case (state_reg)
         ST_IDLE: begin
            if (eop_in) begin
               zero_cnt_next = 3'd0;
            end else if (bstr_in_valid) begin
               if (!dec_bit) begin
                  zero_cnt_next = (zero_cnt_reg == 3'd7) ? 3'd7 : zero_cnt_reg + 3'd1;
               end else if (zero_cnt_reg >= 3'd6) begin
                  state_next     = ST_DATA;
                  zero_cnt_next  = 3'd0;
                  bit_cnt_next   = 7'd0;
                  pkt_start_next = 1'b1;
`ifdef NRZI_DEC_UNSTUFF_EN
                  ones_cnt_next  = 3'd1;
`endif
               end else begin
                  zero_cnt_next = 3'd0;
               end
            end
         end

         ST_DATA: begin
            // End of packet takes priority; a bit sampled alongside it is dropped.
            if (eop_in) begin
               state_next    = ST_IDLE;
               zero_cnt_next = 3'd0;
               pkt_end_next  = 1'b1;
            end else if (bstr_in_valid) begin
               if (bit_cnt_reg == MAX_BITS) begin
                  state_next     = ST_ERR;
                  stuff_err_next = 1'b1;
               end else begin
`ifdef NRZI_DEC_UNSTUFF_EN
                  if (ones_cnt_reg == 3'd6) begin
                     if (dec_bit) begin
                        state_next     = ST_ERR;
                        stuff_err_next = 1'b1;
                     end else begin
                        ones_cnt_next = 3'd0;
                     end
                  end else begin
                     deliver       = 1'b1;
                     ones_cnt_next = dec_bit ? ones_cnt_reg + 3'd1 : 3'd0;
                  end
`else
                  deliver = 1'b1;
`endif
               end
            end
         end

         ST_ERR: begin
            if (eop_in) begin
               state_next    = ST_IDLE;
               zero_cnt_next = 3'd0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (deliver) begin
         bstr_out_next       = dec_bit;
         bstr_out_valid_next = 1'b1;
         bit_cnt_next        = bit_cnt_reg + 7'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= ST_IDLE;
         prev_line_reg      <= 1'b1;
         zero_cnt_reg       <= 3'd0;
         bit_cnt_reg        <= 7'd0;
         bstr_out_reg       <= 1'b0;
         bstr_out_valid_reg <= 1'b0;
         pkt_start_reg      <= 1'b0;
         pkt_end_reg        <= 1'b0;
         stuff_err_reg      <= 1'b0;
`ifdef NRZI_DEC_UNSTUFF_EN
         ones_cnt_reg       <= 3'd0;
`endif
      end else begin
         state_reg          <= state_next;
         prev_line_reg      <= prev_line_next;
         zero_cnt_reg       <= zero_cnt_next;
         bit_cnt_reg        <= bit_cnt_next;
         bstr_out_reg       <= bstr_out_next;
         bstr_out_valid_reg <= bstr_out_valid_next;
         pkt_start_reg      <= pkt_start_next;
         pkt_end_reg        <= pkt_end_next;
         stuff_err_reg      <= stuff_err_next;
`ifdef NRZI_DEC_UNSTUFF_EN
         ones_cnt_reg       <= ones_cnt_next;
`endif
      end
   end

   assign bstr_out       = bstr_out_reg;
   assign bstr_out_valid = bstr_out_valid_reg;
   assign pkt_start      = pkt_start_reg;
   assign pkt_end        = pkt_end_reg;
   assign stuff_err      = stuff_err_reg;
   assign bit_cnt        = bit_cnt_reg;

endmodule

// File: tb/tb_nrzi_dec.sv
// Directed, table-driven bench for nrzi_dec; unstuffing vectors follow NRZI_DEC_UNSTUFF_EN.
module tb_nrzi_dec;

   logic       clk = 1'b0;
   logic       rst;
   logic       bstr_in;
   logic       bstr_in_valid;
   logic       eop_in;
   logic       bstr_out;
   logic       bstr_out_valid;
   logic       pkt_start;
   logic       pkt_end;
   logic       stuff_err;
   logic [6:0] bit_cnt;

   always #5 clk = ~clk;

   nrzi_dec dut (
      .clk            (clk),
      .rst            (rst),
      .bstr_in        (bstr_in),
      .bstr_in_valid  (bstr_in_valid),
      .eop_in         (eop_in),
      .bstr_out       (bstr_out),
      .bstr_out_valid (bstr_out_valid),
      .pkt_start      (pkt_start),
      .pkt_end        (pkt_end),
      .stuff_err      (stuff_err),
      .bit_cnt        (bit_cnt)
   );

   typedef struct {
      logic r, v, e, l;
      logic eo, ev, es, ee, er;
      int   ec;
   } vec_t;

   vec_t vecs[$];
   logic tb_line;
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   task automatic chk(string name, int idx, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add_raw(logic r, logic v, logic e, logic l,
                          logic eo, logic ev, logic es, logic ee, logic er, int ec);
      vec_t t;
      t.r = r; t.v = v; t.e = e; t.l = l;
      t.eo = eo; t.ev = ev; t.es = es; t.ee = ee; t.er = er; t.ec = ec;
      vecs.push_back(t);
      if (r || e)
         tb_line = 1'b1;
      else if (v)
         tb_line = l;
   endtask

   // Encode one decoded bit onto the line relative to the previous line level.
   task automatic add_d(logic d, logic eo, logic ev, logic es, logic ee, logic er, int ec);
      logic l;
      l = d ? tb_line : ~tb_line;
      add_raw(1'b0, 1'b1, 1'b0, l, eo, ev, es, ee, er, ec);
   endtask

   task automatic add_sync(int cnt_before);
      for (int i = 0; i < 7; i++)
         add_d(1'b0, 0, 0, 0, 0, 0, cnt_before);
      add_d(1'b1, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic run_table();
      foreach (vecs[i]) begin
         rst           = vecs[i].r;
         bstr_in_valid = vecs[i].v;
         eop_in        = vecs[i].e;
         bstr_in       = vecs[i].l;
         @(posedge clk);
         #1;
         chk("bstr_out_valid", vec_no, int'(bstr_out_valid), int'(vecs[i].ev));
         if (vecs[i].ev)
            chk("bstr_out", vec_no, int'(bstr_out), int'(vecs[i].eo));
         chk("pkt_start", vec_no, int'(pkt_start), int'(vecs[i].es));
         chk("pkt_end", vec_no, int'(pkt_end), int'(vecs[i].ee));
         chk("stuff_err", vec_no, int'(stuff_err), int'(vecs[i].er));
         chk("bit_cnt", vec_no, int'(bit_cnt), vecs[i].ec);
         $display("vec %0d: rst=%0b v=%0b eop=%0b line=%0b -> out=%0b vld=%0b st=%0b end=%0b err=%0b cnt=%0d",
                  vec_no, vecs[i].r, vecs[i].v, vecs[i].e, vecs[i].l,
                  bstr_out, bstr_out_valid, pkt_start, pkt_end, stuff_err, bit_cnt);
         vec_no++;
      end
      vecs.delete();
   endtask

   initial begin
      int c;
      logic [7:0] pay;
      rst           = 1'b1;
      bstr_in       = 1'b1;
      bstr_in_valid = 1'b0;
      eop_in        = 1'b0;
      tb_line       = 1'b1;

      // Reset, SYNC, 0xA5 payload, hold, EOP colliding with a valid bit.
      add_raw(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add_raw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add_sync(0);
      pay = 8'hA5;
      for (int i = 0; i < 8; i++)
         add_d(pay[i], pay[i], 1, 0, 0, 0, i + 1);
      add_raw(0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
      add_raw(0, 1, 1, 0, 0, 0, 0, 1, 0, 8);
      add_raw(0, 0, 0, 1, 0, 0, 0, 0, 0, 8);
      add_sync(8);
`ifdef NRZI_DEC_UNSTUFF_EN
      for (int i = 1; i <= 5; i++)
         add_d(1, 1, 1, 0, 0, 0, i);
      add_d(0, 0, 0, 0, 0, 0, 5);
      add_d(1, 1, 1, 0, 0, 0, 6);
      add_raw(0, 0, 1, 1, 0, 0, 0, 1, 0, 6);
      add_sync(6);
      for (int i = 1; i <= 5; i++)
         add_d(1, 1, 1, 0, 0, 0, i);
      add_d(1, 0, 0, 0, 0, 1, 5);
      add_d(1, 0, 0, 0, 0, 0, 5);
      add_d(0, 0, 0, 0, 0, 0, 5);
      add_raw(0, 0, 1, 1, 0, 0, 0, 0, 0, 5);
      c = 5;
`else
      for (int i = 1; i <= 7; i++)
         add_d(1, 1, 1, 0, 0, 0, i);
      add_raw(0, 0, 1, 1, 0, 0, 0, 1, 0, 7);
      c = 7;
`endif
      // IDLE: EOP interrupts a zero run; five zeros are too few; six start a packet.
      for (int i = 0; i < 4; i++) add_d(0, 0, 0, 0, 0, 0, c);
      add_raw(0, 0, 1, 1, 0, 0, 0, 0, 0, c);
      for (int i = 0; i < 3; i++) add_d(0, 0, 0, 0, 0, 0, c);
      add_d(1, 0, 0, 0, 0, 0, c);
      for (int i = 0; i < 5; i++) add_d(0, 0, 0, 0, 0, 0, c);
      add_d(1, 0, 0, 0, 0, 0, c);
      for (int i = 0; i < 6; i++) add_d(0, 0, 0, 0, 0, 0, c);
      add_d(1, 0, 0, 1, 0, 0, 0);
      add_raw(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      // Overflow: 92 bits accepted, the 93rd errors, ERR ignores bits and has no pkt_end.
      add_sync(0);
      for (int i = 1; i <= 92; i++)
         add_d(logic'(i % 2), logic'(i % 2), 1, 0, 0, 0, i);
      add_d(1, 0, 0, 0, 0, 1, 92);
      add_d(0, 0, 0, 0, 0, 0, 92);
      add_raw(0, 0, 1, 1, 0, 0, 0, 0, 0, 92);
      run_table();

      // Asynchronous reset mid-packet must clear outputs without waiting for an edge.
      add_sync(92);
      add_d(1, 1, 1, 0, 0, 0, 1);
      add_d(0, 0, 1, 0, 0, 0, 2);
      run_table();
      rst = 1'b1;
      #1;
      chk("rst_async_valid", vec_no, int'(bstr_out_valid), 0);
      chk("rst_async_bit_cnt", vec_no, int'(bit_cnt), 0);
      chk("rst_async_pulses", vec_no, int'({pkt_start, pkt_end, stuff_err, bstr_out}), 0);
      $display("async rst: vld=%0b cnt=%0d", bstr_out_valid, bit_cnt);
      @(posedge clk);
      #1;
      rst_release: begin
         rst           = 1'b0;
         bstr_in_valid = 1'b0;
      end
      tb_line = 1'b1;
      add_sync(0);
      add_d(1, 1, 1, 0, 0, 0, 1);
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
